counter_rr_sched: RTL and testbench

Round-robin scheduler that shares one loadable up-counter datapath among N_REQ requesters. For each granted job it loads the requester's start value, then counts up for the requested number of clocks. It then reports completion and moves on to the next requester. It sits between client blocks and the shared counter, and replaces ad-hoc driving of the load strobe and load value.

---
 rtl/counter_rr_sched.sv | 130 +++++++++++++
 tb/tb_counter_rr_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler that time-shares one loadable up-counter among N_REQ requesters.
// Each granted job loads its start value, counts len clocks, then pulses done with the owner id.
module counter_rr_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       start_val,
  input  logic [N_REQ*W-1:0]       len,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [W-1:0]             cnt_out,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

  state_t           state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             busy_reg;
  logic [W-1:0]     cnt_reg;
  logic             done_reg;
  logic [IW-1:0]    done_id_reg;
  logic [IW-1:0]    last_id_reg;
  logic [IW-1:0]    owner_reg;
  logic [W-1:0]     start_reg;
  logic [W-1:0]     len_reg;
  logic [W-1:0]     rem_reg;

  logic [W-1:0]     start_arr [N_REQ];
  logic [W-1:0]     len_arr   [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign start_arr[gi] = start_val[gi*W +: W];
    assign len_arr[gi]   = len[gi*W +: W];
  end

  // Rotate req so bit 0 is the requester right after last_id, then take the lowest set bit.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IW:0]        rot_base;
  logic [IW:0]        pick_sum;
  logic [IW-1:0]      pick_pos;
  logic [IW-1:0]      pick_id;
  logic               pick_valid;

  assign req_dbl  = {req, req};
  assign rot_base = {1'b0, last_id_reg} + (IW+1)'(1);
  assign req_rot  = N_REQ'(req_dbl >> rot_base);

  always_comb begin
    pick_valid = 1'b0;
    pick_pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_valid = 1'b1;
        pick_pos   = IW'(i);
      end
    end
  end

  assign pick_sum = rot_base + {1'b0, pick_pos};
  assign pick_id  = (pick_sum >= (IW+1)'(N_REQ)) ? IW'(pick_sum - (IW+1)'(N_REQ)) : IW'(pick_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      last_id_reg <= IW'(N_REQ - 1);
      owner_reg   <= '0;
      start_reg   <= '0;
      len_reg     <= '0;
      rem_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_id;
            start_reg <= start_arr[pick_id];
            len_reg   <= len_arr[pick_id];
            grant_reg <= N_REQ'(1) << pick_id;
            busy_reg  <= 1'b1;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_reg   <= start_reg;
          rem_reg   <= len_reg;
          state_reg <= (len_reg == '0) ? S_DONE : S_COUNT;
        end
        S_COUNT: begin
          cnt_reg <= cnt_reg + W'(1);
          rem_reg <= rem_reg - W'(1);
          if (rem_reg == W'(1)) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          // First cycle raises done; the second drops it and releases the counter.
          if (!done_reg) begin
            done_reg    <= 1'b1;
            done_id_reg <= owner_reg;
            last_id_reg <= owner_reg;
          end else begin
            done_reg  <= 1'b0;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign cnt_out = cnt_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Bench for counter_rr_sched: job-level reference model checked every cycle,
// a table of single jobs, hand-written round-robin and abort sequences, then random traffic.
module tb_counter_rr_sched;
  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IW    = $clog2(N_REQ);

  typedef struct {
    int id;
    int start;
    int len;
    int exp_final;
  } job_vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   start_val;
  logic [N_REQ*W-1:0]   len;
  logic [N_REQ-1:0]     grant;
  logic                 busy;
  logic [W-1:0]         cnt_out;
  logic                 done;
  logic [IW-1:0]        done_id;

  int vectors     = 0;
  int miscompares = 0;

  // Job-level model: t counts edges since the grant edge of the active job.
  bit m_active;
  int m_id, m_start, m_len, m_t, m_last, m_hold;

  counter_rr_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .start_val(start_val), .len(len),
    .grant(grant), .busy(busy), .cnt_out(cnt_out), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [N_REQ-1:0] r, int last);
    for (int off = 1; off <= N_REQ; off++) begin
      if (((r >> ((last + off) % N_REQ)) & 1) != 0) return (last + off) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = N_REQ - 1;
    m_hold   = 0;
    m_t      = 0;
  endtask

  task automatic model_edge();
    int p;
    if (!m_active) begin
      p = rr_pick(req, m_last);
      if (p >= 0) begin
        m_active = 1'b1;
        m_id     = p;
        m_start  = int'(start_val[p*W +: W]);
        m_len    = int'(len[p*W +: W]);
        m_t      = 0;
      end
    end else begin
      m_t++;
      if (m_t == m_len + 3) begin
        m_active = 1'b0;
        m_last   = m_id;
        m_hold   = (m_start + m_len) % (1 << W);
      end
    end
  endtask

  task automatic check_cycle();
    int e_cnt;
    int e_grant;
    bit e_done;
    e_grant = m_active ? (1 << m_id) : 0;
    if (m_active && m_t >= 1)
      e_cnt = (m_start + ((m_t - 1 < m_len) ? m_t - 1 : m_len)) % (1 << W);
    else
      e_cnt = m_hold;
    e_done = m_active && (m_t == m_len + 2);
    check("grant", int'(grant), e_grant);
    check("busy", int'(busy), int'(m_active));
    check("cnt_out", int'(cnt_out), e_cnt);
    check("done", int'(done), int'(e_done));
    if (e_done) check("done_id", int'(done_id), m_id);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_cycle();
  endtask

  task automatic set_job(int id, int s, int l);
    start_val[id*W +: W] = W'(s);
    len[id*W +: W]       = W'(l);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy; i++) step();
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    job_vec_t         jobs [5];
    logic [N_REQ-1:0] exp_rr [7];
    logic [N_REQ-1:0] prev;
    int               n;
    int               got;
    bit               seen;

    jobs[0] = '{0, 30, 1, 31};
    jobs[1] = '{2, 37, 5, 42};
    jobs[2] = '{1, 255, 255, 254};
    jobs[3] = '{0, 254, 3, 1};
    jobs[4] = '{3, 9, 0, 9};
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    // Reset held with all requests asserted.
    rst_n = 1'b0; req = '1; start_val = '0; len = '0;
    model_reset();
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    check("first_grant", int'(grant), 1);
    req = '0;
    wait_idle();

    // Table of isolated jobs; request and inputs are scrambled right after grant.
    foreach (jobs[j]) begin
      set_job(jobs[j].id, jobs[j].start, jobs[j].len);
      req  = N_REQ'(1) << jobs[j].id;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        step();
        seen = (grant != '0);
      end
      check("tbl_grant", int'(grant), 1 << jobs[j].id);
      req       = '0;
      start_val = (N_REQ*W)'($urandom);
      len       = (N_REQ*W)'($urandom);
      n = 0;
      while (!done && n < 300) begin
        step();
        n++;
      end
      check("tbl_latency", n, jobs[j].len + 2);
      check("tbl_final", int'(cnt_out), jobs[j].exp_final);
      check("tbl_done_id", int'(done_id), jobs[j].id);
      step();
      check("tbl_hold", int'(cnt_out), jobs[j].exp_final);
      check("tbl_done_low", int'(done), 0);
    end

    // Round-robin with all requesters, then a sparse pattern after last_id=0.
    for (int i = 0; i < N_REQ; i++) set_job(i, 10 * i, 1);
    req  = '1;
    got  = 0;
    prev = '0;
    for (int c = 0; c < 200 && got < 7; c++) begin
      step();
      if (grant != '0 && prev == '0) begin
        check("rr_grant", int'(grant), int'(exp_rr[got]));
        got++;
        if (got == 5) req = 4'b1010;
      end
      prev = grant;
    end
    check("rr_count", got, 7);
    req = '0;
    wait_idle();

    // Abort mid-count, then re-request restarts from the start value.
    set_job(0, 100, 10);
    req = 4'b0001;
    for (int c = 0; c < 20 && !(busy && cnt_out == 8'd104); c++) step();
    check("abort_reach", int'(cnt_out), 104);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_cycle();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("abort_regrant", int'(grant), 1);
    step();
    check("abort_restart", int'(cnt_out), 100);
    req = '0;
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 1) == 1) set_job(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 6)));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
